// File: rtl/uart_rx_fifo.sv
// Receive byte buffer: edge-detected write from uart_rx_control into a FWFT FIFO with overflow flag.
// Define UART_RX_FIFO_STATS_EN to build the saturating drop_count counter; otherwise drop_count is tied to 0.
module uart_rx_fifo #(
    parameter int unsigned FRAME_SIZE = 8,
    parameter int unsigned DEPTH      = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [FRAME_SIZE-1:0]   rx_data,
    input  logic                    rx_complete,
    output logic [FRAME_SIZE-1:0]   rd_data,
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty,
    output logic                    overflow,
    input  logic                    overflow_clr,
    output logic [15:0]             drop_count
);

    localparam int unsigned ADDR = $clog2(DEPTH);
    localparam int unsigned CW   = ADDR + 1;

    logic [FRAME_SIZE-1:0] mem [DEPTH];

    logic [ADDR:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            overflow_q, overflow_d;
    logic            rx_complete_q;

    logic wr_req, rd_fire, wr_accept, drop;

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign rd_valid  = ~empty;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign rd_data   = mem[rd_ptr_q[ADDR-1:0]];

    assign wr_req    = rx_complete & ~rx_complete_q;
    assign rd_fire   = rd_valid & rd_ready;
    // A read in the same cycle frees the slot the write lands in, so a full FIFO still accepts.
    assign wr_accept = wr_req & (~full | rd_fire);
    assign drop      = wr_req & full & ~rd_fire;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (wr_accept) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_fire)   rd_ptr_d = rd_ptr_q + 1'b1;
        case ({wr_accept, rd_fire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (drop)              overflow_d = 1'b1;
        else if (overflow_clr) overflow_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            overflow_q    <= 1'b0;
            rx_complete_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            overflow_q    <= overflow_d;
            rx_complete_q <= rx_complete;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_accept) mem[wr_ptr_q[ADDR-1:0]] <= rx_data;
    end

`ifdef UART_RX_FIFO_STATS_EN
    logic [15:0] drop_count_q, drop_count_d;

    always_comb begin
        drop_count_d = drop_count_q;
        if (overflow_clr)                         drop_count_d = drop ? 16'd1 : 16'd0;
        else if (drop && drop_count_q != 16'hFFFF) drop_count_d = drop_count_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) drop_count_q <= '0;
        else        drop_count_q <= drop_count_d;
    end

    assign drop_count = drop_count_q;
`else
    assign drop_count = '0;
`endif

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side byte buffer directly downstream of uart_rx_control. Captures each received frame on the rising edge of rx_complete and queues it in a first-word-fall-through FIFO. Presents bytes on a valid/ready read port to consumers such as uart_tx_control start logic or a command parser. Decouples the bursty 9600-baud receive path from slower or stalled consumers and flags overruns.

Parameters:
FRAME_SIZE, 8, data bits per received frame; width of rx_data and rd_data.
DEPTH, 16, FIFO entries; power of two, minimum 2.

Ports:
clk  input  1  system clock (100 MHz)
rst_n  input  1  asynchronous active-low reset
rx_data  input  FRAME_SIZE  received byte from uart_rx_control
rx_complete  input  1  frame-done strobe from uart_rx_control; pulse or held level
rd_data  output  FRAME_SIZE  head-of-FIFO byte; meaningful only when rd_valid=1
rd_valid  output  1  FIFO non-empty
rd_ready  input  1  consumer accepts head byte this cycle
count  output  $clog2(DEPTH)+1  number of stored bytes, 0..DEPTH
full  output  1  count==DEPTH
empty  output  1  count==0
overflow  output  1  sticky: a byte was dropped because the FIFO was full
overflow_clr  input  1  synchronous clear of overflow
drop_count  output  16  dropped-byte counter (see Optional Feature)

Behaviour:
- Reset (rst_n low, async): wr_ptr=rd_ptr=0, count=0, empty=1, full=0, rd_valid=0, overflow=0, drop_count=0, rx_complete_q=0. rd_data is don't-care. Memory contents are not reset.
- Write detect: rx_complete_q registers rx_complete every cycle. wr_req = rx_complete & ~rx_complete_q. A held level produces exactly one write. A pulse of 1 cycle is sufficient.
- rx_data is sampled in the wr_req cycle.
- Read: rd_fire = rd_valid & rd_ready. rd_ready while empty is ignored.
- rd_valid = ~empty, registered via count. rd_data = mem[rd_ptr[ADDR-1:0]], combinational from the head entry (FWFT).
- Latency: a byte written in cycle N is visible on rd_data with rd_valid=1 in cycle N+1.
- Pointers: ADDR=$clog2(DEPTH) bits plus one wrap bit. They wrap naturally modulo 2*DEPTH.
- count updates per cycle:
  - +1 on an accepted write without a read.
  - -1 on a read without a write.
  - Unchanged on an accepted write plus a read, or when neither occurs.
- Full + wr_req + rd_fire in the same cycle: the write is accepted, because the read frees a slot. count stays DEPTH and overflow is not set.
- Full + wr_req without rd_fire: the byte is dropped, pointers are unchanged, and overflow is set to 1 on the next edge.
- Empty + wr_req: the write is accepted. rd_fire cannot occur because rd_valid=0.
- overflow: set by a drop, cleared by overflow_clr. If a drop and overflow_clr occur in the same cycle, set wins.
- Reset asserted mid-operation discards all contents immediately. After release, the first rising edge of rx_complete is needed to write; a level already high at release is written once, since rx_complete_q=0.

Optional Feature:
UART_RX_FIFO_STATS_EN
- Defined: drop_count increments by 1 on every dropped byte and saturates at 16'hFFFF. overflow_clr also clears drop_count to 0; if a drop and overflow_clr occur in the same cycle, drop_count becomes 1.
- Undefined: no counter logic is built and drop_count is tied to 0.

Test Plan:
- Reset, then one rx_complete pulse with rx_data=8'hA5 -> next cycle rd_valid=1, rd_data=8'hA5, count=1. Assert rd_ready one cycle -> empty=1, count=0.
- rx_complete held high 5 cycles with rx_data=8'h3C -> exactly one entry, count=1.
- Write 16 bytes 0x00..0x0F with rd_ready=0 -> full=1. Write 17th byte 0xFF -> count=16, overflow=1, drop_count=1 (STATS_EN defined). Drain 16 reads -> sequence 0x00..0x0F in order, 0xFF never appears.
- Full FIFO, wr_req with 0x77 and rd_ready=1 in the same cycle -> overflow stays 0, count=16, 0x77 read out last.
- Wrap-around: 40 interleaved writes/reads of an incrementing pattern with random rd_ready -> output order matches input order and count never exceeds 16.
- overflow=1, then a drop and overflow_clr in the same cycle -> overflow=1 and drop_count=1. Assert rst_n low with 3 entries stored -> count=0, rd_valid=0 asynchronously.
